// File: rtl/scaled_pixel_collector.sv
// scaled_pixel_collector
// Collects scaled pixels from a strobe-only datapath, tags each with its
// (x, y) position in the target frame and queues {value, x, y} in a
// first-word-fall-through FIFO towards a valid/ready consumer.
//
// Output handshake: out_valid is high whenever the FIFO holds an entry and
// out_data/out_x/out_y show that head entry. An entry leaves the FIFO on a
// rising edge where out_valid & out_ready are both high. While out_valid is
// high and out_ready is low the head entry (and so all three data outputs)
// stays put. The input side has no backpressure: a pixel that arrives while
// the FIFO is full and nothing is leaving is dropped and flagged in overflow.
module scaled_pixel_collector #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] tw,
  input  logic [15:0] th,
  input  logic        pixel_rdy,
  input  logic [15:0] pixel_val,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  input  logic        out_ready,
  output logic        busy,
  output logic        row_done,
  output logic        frame_done,
  output logic        overflow,
  output logic [15:0] checksum,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Frame geometry captured on the accepted start; the live tw/th inputs are
  // ignored for the rest of the frame.
  logic [15:0] tw_q;
  logic [15:0] th_q;
  logic [15:0] x_q;
  logic [15:0] y_q;
  logic [15:0] checksum_q;
  logic        overflow_q;
  logic        row_done_q;
  logic        frame_done_q;

  // FIFO storage: pointers carry one extra bit so full and empty differ.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [47:0] mem [DEPTH];
  logic [47:0] head;

  logic fifo_empty;
  logic fifo_full;
  logic start_ok;
  logic accept;
  logic push;
  logic pop;
  logic last_x;
  logic last_y;
  logic zero_size;

  // Handshake and bookkeeping decodes shared by the FSM and datapath.
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    start_ok   = (state == S_IDLE) && start;
    accept     = (state == S_COLLECT) && pixel_rdy;
    // A pop needs a real head entry, so an empty FIFO never pops.
    pop        = !fifo_empty && out_ready;
    // A full FIFO still takes the pixel when the head leaves on the same edge.
    push       = accept && (!fifo_full || pop);
    last_x     = (x_q == tw_q - 16'd1);
    last_y     = (y_q == th_q - 16'd1);
    zero_size  = (tw == 16'd0) || (th == 16'd0);
  end

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = zero_size ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept && last_x && last_y) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame position, checksum and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tw_q         <= 16'd0;
      th_q         <= 16'd0;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      checksum_q   <= 16'd0;
      overflow_q   <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      row_done_q   <= accept && last_x;
      frame_done_q <= (state == S_DONE);
      if (start_ok) begin
        tw_q       <= tw;
        th_q       <= th;
        x_q        <= 16'd0;
        y_q        <= 16'd0;
        checksum_q <= 16'd0;
        overflow_q <= 1'b0;
      end else if (accept) begin
        // Dropped pixels still count towards position and checksum.
        checksum_q <= checksum_q + pixel_val;
        if (last_x) begin
          x_q <= 16'd0;
          y_q <= y_q + 16'd1;
        end else begin
          x_q <= x_q + 16'd1;
        end
        if (!push) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  // FIFO pointers; both wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // FIFO storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {pixel_val, x_q, y_q};
    end
  end

  // Head entry presented combinationally, forced to zero when empty.
  always_comb begin
    head      = mem[rd_ptr[AW-1:0]];
    out_valid = !fifo_empty;
    out_data  = out_valid ? head[47:32] : 16'd0;
    out_x     = out_valid ? head[31:16] : 16'd0;
    out_y     = out_valid ? head[15:0]  : 16'd0;
  end

  // Status outputs.
  always_comb begin
    busy       = (state != S_IDLE);
    row_done   = row_done_q;
    frame_done = frame_done_q;
    overflow   = overflow_q;
    checksum   = checksum_q;
    state_dbg  = state;
  end

endmodule

// File: tb/tb_scaled_pixel_collector.sv
// Directed bench for scaled_pixel_collector: output stream checked against
// an expected queue of {value, x, y}, status flags checked at fixed points.
module tb_scaled_pixel_collector;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] tw;
  logic [15:0] th;
  logic        pixel_rdy;
  logic [15:0] pixel_val;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic        out_ready;
  logic        busy;
  logic        row_done;
  logic        frame_done;
  logic        overflow;
  logic [15:0] checksum;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int failed    = 0;
  int row_cnt   = 0;
  int frame_cnt = 0;
  int pop_cnt   = 0;

  logic [47:0] exp_q[$];

  logic        prev_stall = 1'b0;
  logic [47:0] prev_head  = '0;

  scaled_pixel_collector #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .tw(tw), .th(th),
    .pixel_rdy(pixel_rdy), .pixel_val(pixel_val),
    .out_valid(out_valid), .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .out_ready(out_ready), .busy(busy), .row_done(row_done),
    .frame_done(frame_done), .overflow(overflow), .checksum(checksum),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] ent(input int v, input int x, input int y);
    logic [15:0] v16;
    logic [15:0] x16;
    logic [15:0] y16;
    v16 = v[15:0];
    x16 = x[15:0];
    y16 = y[15:0];
    return {v16, x16, y16};
  endfunction

  // Output monitor: scoreboard pops, stall stability, pulse counting.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (row_done) row_cnt++;
      if (frame_done) frame_cnt++;
      if (prev_stall) begin
        check("stall_valid", {47'd0, out_valid}, 48'd1);
        check("stall_stable", {out_data, out_x, out_y}, prev_head);
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", {out_data, out_x, out_y}, 48'hFFFF_FFFF_FFFF);
        end else begin
          check("out_entry", {out_data, out_x, out_y}, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_head  = {out_data, out_x, out_y};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] w, input logic [15:0] h);
    start = 1'b1;
    tw    = w;
    th    = h;
    tick();
    start = 1'b0;
    tw    = 16'($urandom);
    th    = 16'($urandom);
  endtask

  task automatic send_pixel(input int v);
    pixel_rdy = 1'b1;
    pixel_val = v[15:0];
    tick();
    pixel_rdy = 1'b0;
    pixel_val = 16'($urandom);
  endtask

  task automatic wait_frame_done(input int budget, input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
      end else if (rnd) begin
        tick();
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    check("frame_done_seen", {47'd0, seen}, 48'd1);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    tw        = 16'd0;
    th        = 16'd0;
    pixel_rdy = 1'b0;
    pixel_val = 16'd0;
    out_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_valid", {47'd0, out_valid}, 48'd0);
    check("rst_busy", {47'd0, busy}, 48'd0);
    check("rst_checksum", {32'd0, checksum}, 48'd0);
    check("rst_state", {46'd0, state_dbg}, 48'd0);
    reset = 1'b0;
    tick();

    // 3x2 frame, consumer always ready
    out_ready = 1'b1;
    row_cnt = 0;
    frame_cnt = 0;
    for (int i = 0; i < 6; i++) exp_q.push_back(ent(10 + i, i % 3, i / 3));
    do_start(16'd3, 16'd2);
    check("a_busy", {47'd0, busy}, 48'd1);
    check("a_state_collect", {46'd0, state_dbg}, 48'd1);
    send_pixel(10);
    check("a_latency_valid", {47'd0, out_valid}, 48'd1);
    check("a_first_sum", {32'd0, checksum}, 48'd10);
    for (int i = 1; i < 6; i++) send_pixel(10 + i);
    wait_frame_done(50, 1'b0);
    check("a_busy_end", {47'd0, busy}, 48'd0);
    check("a_checksum", {32'd0, checksum}, 48'd75);
    @(negedge clk);
    check("a_row_pulses", 48'(row_cnt), 48'd2);
    check("a_frame_pulses", 48'(frame_cnt), 48'd1);
    check("a_queue_empty", 48'(exp_q.size()), 48'd0);
    check("a_overflow", {47'd0, overflow}, 48'd0);
    tick();

    // 20x1 frame into a 16-deep FIFO with the consumer stalled
    out_ready = 1'b0;
    pop_cnt = 0;
    for (int i = 0; i < 16; i++) exp_q.push_back(ent(100 + i, i, 0));
    do_start(16'd20, 16'd1);
    for (int i = 0; i < 20; i++) send_pixel(100 + i);
    check("b_overflow", {47'd0, overflow}, 48'd1);
    check("b_state_drain", {46'd0, state_dbg}, 48'd2);
    check("b_checksum", {32'd0, checksum}, 48'd2190);
    check("b_head", {out_data, out_x, out_y}, ent(100, 0, 0));
    out_ready = 1'b1;
    wait_frame_done(100, 1'b0);
    check("b_pops", 48'(pop_cnt), 48'd16);
    check("b_queue_empty", 48'(exp_q.size()), 48'd0);
    check("b_overflow_sticky", {47'd0, overflow}, 48'd1);
    tick();

    // Full FIFO with push and pop on the same edge
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back(ent(200 + i, i, 0));
    exp_q.push_back(ent(216, 16, 0));
    do_start(16'd20, 16'd1);
    check("c_overflow_cleared", {47'd0, overflow}, 48'd0);
    for (int i = 0; i < 16; i++) send_pixel(200 + i);
    out_ready = 1'b1;
    send_pixel(216);
    out_ready = 1'b0;
    check("c_no_drop", {47'd0, overflow}, 48'd0);
    send_pixel(217);
    check("c_still_full", {47'd0, overflow}, 48'd1);
    send_pixel(218);
    send_pixel(219);
    check("c_checksum", {32'd0, checksum}, 48'd4190);
    out_ready = 1'b1;
    wait_frame_done(100, 1'b0);
    check("c_queue_empty", 48'(exp_q.size()), 48'd0);
    tick();

    // Zero-width frame
    do_start(16'd0, 16'd5);
    check("d_state_done", {46'd0, state_dbg}, 48'd3);
    check("d_fd_early", {47'd0, frame_done}, 48'd0);
    check("d_valid0", {47'd0, out_valid}, 48'd0);
    tick();
    check("d_fd_pulse", {47'd0, frame_done}, 48'd1);
    check("d_busy", {47'd0, busy}, 48'd0);
    check("d_valid1", {47'd0, out_valid}, 48'd0);
    tick();
    check("d_fd_end", {47'd0, frame_done}, 48'd0);

    // Reset mid-frame with two entries still queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(50 + i, i % 3, i / 3));
    do_start(16'd3, 16'd2);
    for (int i = 0; i < 4; i++) send_pixel(50 + i);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("e_queued", {47'd0, out_valid}, 48'd1);
    #2;
    reset = 1'b1;
    #1;
    check("e_async_valid", {47'd0, out_valid}, 48'd0);
    check("e_async_busy", {47'd0, busy}, 48'd0);
    check("e_async_data", {out_data, out_x, out_y}, 48'd0);
    check("e_async_sum", {32'd0, checksum}, 48'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    exp_q.push_back(ent(60, 0, 0));
    exp_q.push_back(ent(61, 1, 0));
    pop_cnt = 0;
    do_start(16'd2, 16'd1);
    send_pixel(60);
    send_pixel(61);
    wait_frame_done(50, 1'b0);
    check("e_pops", 48'(pop_cnt), 48'd2);
    check("e_queue_empty", 48'(exp_q.size()), 48'd0);
    check("e_checksum", {32'd0, checksum}, 48'd121);
    tick();

    // 4x4 frame with a randomly stalling consumer
    for (int i = 0; i < 16; i++) exp_q.push_back(ent(300 + i, i % 4, i / 4));
    do_start(16'd4, 16'd4);
    for (int i = 0; i < 16; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send_pixel(300 + i);
    end
    wait_frame_done(400, 1'b1);
    check("f_queue_empty", 48'(exp_q.size()), 48'd0);
    check("f_checksum", {32'd0, checksum}, 48'd4920);
    check("f_overflow", {47'd0, overflow}, 48'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/scaled_pixel_collector.md
SCALED_PIXEL_COLLECTOR -- requirements
Module: scaled_pixel_collector

Interface
REQ-001 SHALL have parameter: DEPTH, 16, output FIFO depth in entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  frame start request, sampled in IDLE only.
REQ-005 SHALL have ports: tw, th  input  16 each  target frame width and height in pixels, latched on accepted start.
REQ-006 SHALL have ports: pixel_rdy  input  1, and pixel_val  input  16; pixel_rdy is a one-cycle strobe qualifying pixel_val from the scaling datapath; there is no backpressure.
REQ-007 SHALL have ports: out_valid  output  1, out_data  output  16, out_x  output  16, out_y  output  16, out_ready  input  1; together these form the valid/ready pixel output with coordinates.
REQ-008 SHALL have ports: busy  output  1, row_done  output  1 (pulse), frame_done  output  1 (pulse), overflow  output  1 (sticky), checksum  output  16.

Function
REQ-009 SHALL implement FSM states IDLE, COLLECT, DRAIN, DONE.
REQ-010 IDLE + start: SHALL latch tw/th, clear x, y, checksum, overflow; go to COLLECT, or to DONE if tw==0 or th==0.
REQ-011 COLLECT: each pixel_rdy SHALL be accepted, with {pixel_val, x, y} pushed to the FIFO when there is space.
REQ-012 Per accepted pixel: x SHALL increment; at x==tw-1, x SHALL wrap to 0, y SHALL increment, and row_done SHALL pulse high for exactly the following cycle.
REQ-013 Accepting the pixel at x==tw-1, y==th-1 SHALL move the FSM to DRAIN; pixel_rdy SHALL then be ignored until the next frame.
REQ-014 DRAIN: SHALL stay until the FIFO is empty, then go to DONE.
REQ-015 DONE: frame_done SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-016 busy SHALL be high in every state except IDLE.
REQ-017 start outside IDLE SHALL be ignored; pixel_rdy in IDLE or DONE SHALL be ignored with no state change.
REQ-018 checksum SHALL be the modulo-2^16 sum of pixel_val over all pixels accepted in COLLECT, including dropped ones; it SHALL update 1 cycle after acceptance.
REQ-019 FIFO: first-word-fall-through; out_valid SHALL equal not-empty; out_data/out_x/out_y SHALL show the head entry; a pop SHALL occur on out_valid & out_ready.
REQ-020 While out_valid & ~out_ready, out_data/out_x/out_y SHALL remain stable.
REQ-021 Latency SHALL be: pixel_rdy at edge N -> out_valid high after edge N+1 when the FIFO was empty.
REQ-022 Full FIFO with push and no pop: pixel SHALL be dropped, overflow SHALL set and hold until the next accepted start, and x/y/checksum SHALL still advance.
REQ-023 Full FIFO with simultaneous push and pop: both SHALL occur with no drop and the count unchanged.
REQ-024 Empty FIFO with simultaneous push and pop request: out_valid is low so there SHALL be no pop; the push SHALL occur.
REQ-025 FIFO read/write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit or a count.
REQ-026 Width rules: x and y SHALL be 16-bit unsigned; the comparison against tw-1 and th-1 SHALL use latched values; tw and th inputs SHALL be don't-care outside the start cycle.

Reset
REQ-027 Asserting reset at any time, including mid-frame, SHALL immediately force: state IDLE; x, y, checksum = 0; FIFO empty; out_valid, busy, row_done, frame_done, overflow = 0; out_data, out_x, out_y = 0.
REQ-028 After reset deassertion, the first start SHALL behave per REQ-010 with no residual FIFO contents.

Verification
REQ-029 Scenario: tw=3, th=2, six pixel_rdy strobes with values 10..15, out_ready=1 -> outputs (10,0,0),(11,1,0),(12,2,0),(13,0,1),(14,1,1),(15,2,1); row_done pulses twice; checksum=75; frame_done pulses once; busy returns to 0.
REQ-030 Scenario: DEPTH=16, tw=20, th=1, out_ready=0, 20 strobes, then out_ready=1 -> 16 entries drain with x=0..15; overflow=1; checksum covers all 20 values; frame_done after the 16th pop.
REQ-031 Scenario: FIFO full, out_ready=1 and pixel_rdy on the same cycle -> no drop, overflow stays 0, count stays 16.
REQ-032 Scenario: start with tw=0, th=5 -> frame_done pulses 2 cycles after start; no out_valid ever.
REQ-033 Scenario: reset asserted after 4 of 6 pixels with 2 entries still queued -> out_valid=0 and busy=0 asynchronously; a new start with tw=2, th=1 yields (v,0,0),(v,1,0) only.
REQ-034 Scenario: out_ready toggled randomly, tw=4, th=4, 16 values -> output order and coordinates match input order exactly; out_data is stable during every stall.
